// File: rtl/sine_rom_arbiter_if.sv
// Bus bundle for the two-channel sine ROM arbiter: request channels, ROM port and scaled output.
interface sine_rom_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
);
  logic              req0;
  logic [ADDR_W-1:0] addr0;
  logic [1:0]        shift0;
  logic              gnt0;
  logic              req1;
  logic [ADDR_W-1:0] addr1;
  logic [1:0]        shift1;
  logic              gnt1;
  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W+1:0] dout;
  logic              dout_valid;
  logic              dout_ch;

  modport slave (
    input  req0, addr0, shift0, req1, addr1, shift1, rom_data,
    output gnt0, gnt1, rom_en, rom_addr, dout, dout_valid, dout_ch
  );

  modport master (
    output req0, addr0, shift0, req1, addr1, shift1, rom_data,
    input  gnt0, gnt1, rom_en, rom_addr, dout, dout_valid, dout_ch
  );
endinterface

// File: rtl/sine_rom_arbiter.sv
// Round-robin arbiter sharing one registered sine ROM between two channels,
// followed by a two-stage pipeline that scales each sample by a per-request left shift.
module sine_rom_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  sine_rom_arbiter_if.slave  bus
);

  function automatic logic [1:0] sat_shift(input logic [1:0] sh);
    return (sh == 2'd3) ? 2'd2 : sh;
  endfunction

  function automatic logic [DATA_W+1:0] scale(input logic [DATA_W-1:0] s, input logic [1:0] sh);
    logic [DATA_W+1:0] ext;
    ext = {2'b00, s};
    return ext << sh;
  endfunction

  logic              prio_q, prio_d;
  logic              gnt0, gnt1, accept;
  logic [ADDR_W-1:0] rom_addr;
  logic              vld_p1_q, vld_p1_d;
  logic              ch_p1_q, ch_p1_d;
  logic [1:0]        shift_p1_q, shift_p1_d;
  logic              vld_p2_q, vld_p2_d;
  logic              ch_p2_q, ch_p2_d;
  logic [DATA_W+1:0] dout_p2_q, dout_p2_d;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (bus.req0 && (!bus.req1 || !prio_q)) gnt0 = 1'b1;
      else if (bus.req1)                     gnt1 = 1'b1;
    end
    accept   = gnt0 | gnt1;
    rom_addr = gnt0 ? bus.addr0 : (gnt1 ? bus.addr1 : '0);
    // prio points at the channel that lost the most recent accept
    prio_d   = gnt0 ? 1'b1 : (gnt1 ? 1'b0 : prio_q);

    // Stage 1: capture request attributes at the accept edge
    vld_p1_d   = accept;
    ch_p1_d    = accept ? gnt1 : ch_p1_q;
    shift_p1_d = accept ? sat_shift(gnt1 ? bus.shift1 : bus.shift0) : shift_p1_q;

    // Stage 2: combine with the ROM word that arrives one cycle after rom_en
    vld_p2_d  = vld_p1_q;
    ch_p2_d   = vld_p1_q ? ch_p1_q : ch_p2_q;
    dout_p2_d = vld_p1_q ? scale(bus.rom_data, shift_p1_q) : dout_p2_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q     <= 1'b0;
      vld_p1_q   <= 1'b0;
      ch_p1_q    <= 1'b0;
      shift_p1_q <= 2'd0;
      vld_p2_q   <= 1'b0;
      ch_p2_q    <= 1'b0;
      dout_p2_q  <= '0;
    end else begin
      prio_q     <= prio_d;
      vld_p1_q   <= vld_p1_d;
      ch_p1_q    <= ch_p1_d;
      shift_p1_q <= shift_p1_d;
      vld_p2_q   <= vld_p2_d;
      ch_p2_q    <= ch_p2_d;
      dout_p2_q  <= dout_p2_d;
    end
  end

  assign bus.gnt0       = gnt0;
  assign bus.gnt1       = gnt1;
  assign bus.rom_en     = accept;
  assign bus.rom_addr   = rom_addr;
  assign bus.dout       = dout_p2_q;
  assign bus.dout_valid = vld_p2_q;
  assign bus.dout_ch    = ch_p2_q;

endmodule
